// File: rtl/lfsr_sym_checker.sv
// LFSR symbol-stream checker: slips a local maximal-length generator into alignment, then monitors the lock.
// Optional macro LFSR_CHK_BITERR_EN adds per-bit error accounting (bit_err_count); otherwise it reads 0.

`ifndef LFSR_LEN
`define LFSR_LEN 16
`endif
`ifndef LFSR_SEED
`define LFSR_SEED 16'hACE1
`endif

module lfsr_gen_max #(
  parameter int LEN = `LFSR_LEN,
  parameter logic [LEN-1:0] SEED = LEN'(`LFSR_SEED)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  output logic [3:0] sym_out
);
  // Fibonacci feedback masks for maximal-length polynomials; unsupported lengths fall back to the 16-bit taps.
  localparam logic [31:0] TAPS32 = (LEN == 8)  ? 32'h0000_00B8 :
                                   (LEN == 24) ? 32'h00E1_0000 :
                                   (LEN == 32) ? 32'h8020_0003 :
                                                 32'h0000_B400;
  localparam logic [LEN-1:0] TAPS = TAPS32[LEN-1:0];

  logic [LEN-1:0] r_lfsr;
  logic           w_fb;

  assign w_fb    = ^(r_lfsr & TAPS);
  assign sym_out = r_lfsr[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[LEN-2:0], w_fb};
    end
  end
endmodule

module lfsr_sym_checker #(
  parameter int CONFIRM_N = 16,
  parameter int LOSS_WIN  = 64,
  parameter int LOSS_THR  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [3:0]  sym_in,
  input  logic        clear_counts,
  output logic        locked,
  output logic [1:0]  state,
  output logic        err_pulse,
  output logic        lock_loss,
  output logic [31:0] sym_count,
  output logic [31:0] sym_err_count,
  output logic [31:0] bit_err_count
);
  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam int RUN_W = $clog2(CONFIRM_N + 1);
  localparam int WIN_W = $clog2(LOSS_WIN + 1);
  localparam int THR_W = $clog2(LOSS_THR + 1);

  logic [1:0]       r_state;
  logic [RUN_W-1:0] r_run;
  logic [WIN_W-1:0] r_win_cnt;
  logic [THR_W-1:0] r_win_err;
  logic             r_err_pulse;
  logic             r_lock_loss;
  logic [31:0]      r_sym_count;
  logic [31:0]      r_sym_err_count;

  logic [3:0]       w_expected;
  logic             w_match;
  logic             w_gen_en;
  logic             w_locked_strobe;
  logic             w_sym_err;
  logic [THR_W-1:0] w_win_err_nxt;
  logic             w_loss;

  // The local generator is held on any hunting/confirming mismatch so the lagging input can catch up.
  assign w_match         = (sym_in == w_expected);
  assign w_gen_en        = clk_en && (w_match || (r_state == ST_LOCKED));
  assign w_locked_strobe = clk_en && (r_state == ST_LOCKED);
  assign w_sym_err       = w_locked_strobe && !w_match;
  assign w_win_err_nxt   = r_win_err + THR_W'(w_sym_err);
  assign w_loss          = w_sym_err && (w_win_err_nxt == THR_W'(LOSS_THR));

  lfsr_gen_max u_gen (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_gen_en),
    .sym_out (w_expected)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_run       <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_pulse <= 1'b0;
      r_lock_loss <= 1'b0;
    end else begin
      r_err_pulse <= w_sym_err;
      r_lock_loss <= w_loss;
      if (clk_en) begin
        case (r_state)
          ST_HUNT: begin
            if (w_match) begin
              r_run   <= RUN_W'(1);
              r_state <= (CONFIRM_N <= 1) ? ST_LOCKED : ST_CONFIRM;
            end else begin
              r_run <= '0;
            end
          end
          ST_CONFIRM: begin
            if (w_match) begin
              r_run <= r_run + RUN_W'(1);
              if ((r_run + RUN_W'(1)) == RUN_W'(CONFIRM_N)) begin
                r_state <= ST_LOCKED;
              end
            end else begin
              r_run   <= '0;
              r_state <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            // Loss takes priority over the window rollover on the same symbol.
            if (w_loss) begin
              r_state   <= ST_HUNT;
              r_run     <= '0;
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else if (r_win_cnt == WIN_W'(LOSS_WIN - 1)) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + WIN_W'(1);
              r_win_err <= w_win_err_nxt;
            end
          end
          default: begin
            r_state <= ST_HUNT;
            r_run   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sym_count     <= '0;
      r_sym_err_count <= '0;
    end else if (clear_counts) begin
      r_sym_count     <= '0;
      r_sym_err_count <= '0;
    end else if (w_locked_strobe) begin
      if (r_sym_count != '1) begin
        r_sym_count <= r_sym_count + 32'd1;
      end
      if (w_sym_err && (r_sym_err_count != '1)) begin
        r_sym_err_count <= r_sym_err_count + 32'd1;
      end
    end
  end

`ifdef LFSR_CHK_BITERR_EN
  logic [3:0]  w_diff;
  logic [2:0]  w_pop;
  logic [32:0] w_bit_sum;
  logic [31:0] r_bit_err_count;

  assign w_diff    = sym_in ^ w_expected;
  assign w_pop     = 3'(w_diff[0]) + 3'(w_diff[1]) + 3'(w_diff[2]) + 3'(w_diff[3]);
  assign w_bit_sum = {1'b0, r_bit_err_count} + 33'(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_err_count <= '0;
    end else if (clear_counts) begin
      r_bit_err_count <= '0;
    end else if (w_locked_strobe) begin
      r_bit_err_count <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
    end
  end

  assign bit_err_count = r_bit_err_count;
`else
  assign bit_err_count = '0;
`endif

  assign state         = r_state;
  assign locked        = (r_state == ST_LOCKED);
  assign err_pulse     = r_err_pulse;
  assign lock_loss     = r_lock_loss;
  assign sym_count     = r_sym_count;
  assign sym_err_count = r_sym_err_count;
endmodule
